// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one asynchronous SRAM between port A (CPU) and port B (PPU/loader).
// Latency: request sampled at edge t -> SRAM strobes for ACC_CYC cycles, ack pulse in cycle t+ACC_CYC+1.
// Backpressure: requesters hold req until their ack; one access in flight, one access per ACC_CYC+2 cycles.
// Ports: m_clock / p_reset (async, active-high);
//        a_* / b_*  : req, we, be, addr, wdata in; ack pulse and registered rdata out;
//        SRAM_*     : registered active-low strobes, DEn (0 = drive Dout onto pad), ADDR, Dout; Din from pad.
module sram_arbiter #(
  parameter int ACC_CYC = 3
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_be,
  input  logic [17:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_be,
  input  logic [17:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        SRAM_CEn,
  output logic        SRAM_OEn,
  output logic        SRAM_WEn,
  output logic        SRAM_LBn,
  output logic        SRAM_UBn,
  output logic        SRAM_DEn,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_Din,
  output logic [15:0] SRAM_Dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_CNT   = CW'(ACC_CYC - 1);
  localparam logic [CW-1:0] WE_LAST_CNT = CW'(ACC_CYC - 2);

  state_t        state;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last_grant;  // 1 = port B was granted last
  logic          gnt_b;       // port owning the current access
  logic          lat_we;
  logic [1:0]    lat_be;

  logic          pick_b;
  logic          sel_we;
  logic [1:0]    sel_be;
  logic [17:0]   sel_addr;
  logic [15:0]   sel_wdata;

  // B wins when it is alone, or on a tie when A was served last.
  always_comb begin
    pick_b    = b_req & (~a_req | ~last_grant);
    sel_we    = pick_b ? b_we    : a_we;
    sel_be    = pick_b ? b_be    : a_be;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    cnt_nxt   = acc_cnt + 1'b1;
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      last_grant <= 1'b1;
      gnt_b      <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= 2'b00;
      SRAM_CEn   <= 1'b1;
      SRAM_OEn   <= 1'b1;
      SRAM_WEn   <= 1'b1;
      SRAM_LBn   <= 1'b1;
      SRAM_UBn   <= 1'b1;
      SRAM_DEn   <= 1'b1;
      SRAM_ADDR  <= '0;
      SRAM_Dout  <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            state      <= ACCESS;
            acc_cnt    <= '0;
            gnt_b      <= pick_b;
            last_grant <= pick_b;
            lat_we     <= sel_we;
            lat_be     <= sel_be;
            SRAM_ADDR  <= sel_addr;
            if (sel_we) SRAM_Dout <= sel_wdata;
            SRAM_CEn   <= 1'b0;
            SRAM_OEn   <= sel_we;
            SRAM_WEn   <= 1'b1;   // first cycle of a write is address/data setup
            SRAM_DEn   <= ~sel_we;
            SRAM_LBn   <= ~sel_be[0];
            SRAM_UBn   <= ~sel_be[1];
          end
        end
        ACCESS: begin
          if (acc_cnt == LAST_CNT) begin
            state    <= DONE;
            SRAM_CEn <= 1'b1;
            SRAM_OEn <= 1'b1;
            SRAM_WEn <= 1'b1;
            SRAM_LBn <= 1'b1;
            SRAM_UBn <= 1'b1;
            SRAM_DEn <= 1'b1;
            a_ack    <= ~gnt_b;
            b_ack    <= gnt_b;
            // Read data settled by now; disabled byte lanes keep their old contents.
            if (!lat_we) begin
              if (gnt_b) begin
                if (lat_be[0]) b_rdata[7:0]  <= SRAM_Din[7:0];
                if (lat_be[1]) b_rdata[15:8] <= SRAM_Din[15:8];
              end else begin
                if (lat_be[0]) a_rdata[7:0]  <= SRAM_Din[7:0];
                if (lat_be[1]) a_rdata[15:8] <= SRAM_Din[15:8];
              end
            end
          end else begin
            acc_cnt  <= cnt_nxt;
            // WEn low only strictly inside the window; last cycle is data hold.
            SRAM_WEn <= ~(lat_we && (cnt_nxt <= WE_LAST_CNT));
          end
        end
        DONE: begin
          state   <= IDLE;
          acc_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req until ack; every wait is bounded.
module tb_sram_arbiter;
  localparam int N = 3;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [1:0]  a_be = 0, b_be = 0;
  logic [17:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_LBn, SRAM_UBn, SRAM_DEn;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_Din = 16'h0;
  logic [15:0] SRAM_Dout;

  sram_arbiter #(.ACC_CYC(N)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .SRAM_CEn(SRAM_CEn), .SRAM_OEn(SRAM_OEn), .SRAM_WEn(SRAM_WEn),
    .SRAM_LBn(SRAM_LBn), .SRAM_UBn(SRAM_UBn), .SRAM_DEn(SRAM_DEn),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_Din(SRAM_Din), .SRAM_Dout(SRAM_Dout)
  );

  always #5 m_clock = ~m_clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;   // rising edges seen outside reset

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- SRAM pad model ----------------
  logic [15:0] mem     [bit [17:0]];
  logic [15:0] ref_mem [bit [17:0]];
  logic [17:0] pool [8];

  always @(negedge m_clock)
    SRAM_Din = (!SRAM_CEn && !SRAM_OEn && mem.exists(SRAM_ADDR)) ? mem[SRAM_ADDR] : 16'h0;

  always @(posedge m_clock) begin
    logic [15:0] w;
    if (!p_reset && !SRAM_CEn && !SRAM_WEn) begin
      w = mem.exists(SRAM_ADDR) ? mem[SRAM_ADDR] : 16'h0;
      if (!SRAM_LBn) w[7:0]  = SRAM_Dout[7:0];
      if (!SRAM_UBn) w[15:8] = SRAM_Dout[15:8];
      mem[SRAM_ADDR] = w;
    end
  end

  // ---------------- transaction-level reference model ----------------
  // A transaction granted at edge st occupies cycles st..st+N-1 on the pad,
  // acks in cycle st+N, and the arbiter samples again at edge st+N+2.
  bit          act = 0;
  int          st = 0;
  bit          last_b = 1;
  bit          t_b = 0, t_we = 0;
  logic [1:0]  t_be = 0;
  logic [17:0] t_addr = 0, exp_addr = 0;
  logic [15:0] t_wd = 0, exp_dout = 0;
  logic [15:0] exp_rd [2] = '{16'h0, 16'h0};

  always @(posedge m_clock or posedge p_reset) begin
    logic [15:0] v;
    if (p_reset) begin
      act = 0; last_b = 1; exp_addr = 0; exp_dout = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
    end else begin
      cyc++;
      if (act && cyc == st + N) begin
        v = ref_mem[t_addr];
        if (t_we) begin
          if (t_be[0]) v[7:0]  = t_wd[7:0];
          if (t_be[1]) v[15:8] = t_wd[15:8];
          ref_mem[t_addr] = v;
        end else begin
          if (t_be[0]) exp_rd[t_b][7:0]  = v[7:0];
          if (t_be[1]) exp_rd[t_b][15:8] = v[15:8];
        end
      end
      if (act && cyc >= st + N + 1) act = 0;
      else if (!act && (a_req || b_req)) begin
        t_b    = (a_req && b_req) ? !last_b : b_req;
        last_b = t_b;
        t_we   = t_b ? b_we : a_we;
        t_be   = t_b ? b_be : a_be;
        t_addr = t_b ? b_addr : a_addr;
        t_wd   = t_b ? b_wdata : a_wdata;
        exp_addr = t_addr;
        if (t_we) exp_dout = t_wd;
        st  = cyc;
        act = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge m_clock) begin
    logic ecen, eoen, ewen, eden, elb, eub, eaa, eab;
    int k;
    ecen = 1; eoen = 1; ewen = 1; eden = 1; elb = 1; eub = 1; eaa = 0; eab = 0;
    if (!p_reset && act) begin
      k = cyc - st;
      if (k < N) begin
        ecen = 0; elb = ~t_be[0]; eub = ~t_be[1];
        if (t_we) begin
          eden = 0;
          ewen = !(k >= 1 && k <= N - 2);
        end else begin
          eoen = 0;
        end
      end else if (k == N) begin
        eaa = !t_b; eab = t_b;
      end
    end
    chk("a_ack", a_ack, eaa);
    chk("b_ack", b_ack, eab);
    chk("CEn", SRAM_CEn, ecen);
    chk("OEn", SRAM_OEn, eoen);
    chk("WEn", SRAM_WEn, ewen);
    chk("DEn", SRAM_DEn, eden);
    chk("LBn", SRAM_LBn, elb);
    chk("UBn", SRAM_UBn, eub);
    chk("ADDR", SRAM_ADDR, exp_addr);
    chk("Dout", SRAM_Dout, exp_dout);
    chk("a_rdata", a_rdata, exp_rd[0]);
    chk("b_rdata", b_rdata, exp_rd[1]);
    chk("acks_exclusive", a_ack & b_ack, 0);
    chk("bus_contention", !SRAM_CEn && !SRAM_OEn && !SRAM_DEn, 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input bit p, input logic rq, input logic we, input logic [1:0] be,
                          input logic [17:0] ad, input logic [15:0] wd);
    if (p) begin b_req = rq; b_we = we; b_be = be; b_addr = ad; b_wdata = wd; end
    else   begin a_req = rq; a_we = we; a_be = be; a_addr = ad; a_wdata = wd; end
  endtask

  task automatic do_req(input bit p, input logic we, input logic [1:0] be,
                        input logic [17:0] ad, input logic [15:0] wd,
                        output int lat, output int cen, output int oen, output int wen,
                        output int wen_pos, output int den, output int lb, output int ub);
    int t0;
    bit got;
    lat = -1; cen = 0; oen = 0; wen = 0; wen_pos = -1; den = 0; lb = 0; ub = 0; got = 0;
    @(negedge m_clock);
    set_port(p, 1, we, be, ad, wd);
    t0 = cyc;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge m_clock);
      if (!SRAM_CEn) begin
        if (!SRAM_WEn && wen == 0) wen_pos = cen;
        if (!SRAM_OEn) oen++;
        if (!SRAM_WEn) wen++;
        if (!SRAM_DEn) den++;
        if (!SRAM_LBn) lb++;
        if (!SRAM_UBn) ub++;
        cen++;
      end
      if (p ? b_ack : a_ack) begin got = 1; lat = cyc - t0; end
    end
    chk("ack_seen", got, 1);
    set_port(p, 0, we, be, ad, wd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, cen, oen, wen, wpos, den, lb, ub;
    int ack_port[$];
    int ack_cyc[$];
    bit got;
    logic [15:0] old_hi;

    pool = '{18'h00123, 18'h3FFFF, 18'h00000, 18'h1A5A5, 18'h20001, 18'h0FFFF, 18'h2AAAA, 18'h15555};
    for (int i = 0; i < 8; i++) begin
      mem[pool[i]] = 16'($urandom);
    end
    mem[18'h00123] = 16'hBEEF;
    mem[18'h1A5A5] = 16'hABCD;
    for (int i = 0; i < 8; i++) ref_mem[pool[i]] = mem[pool[i]];

    #1 p_reset = 1;
    repeat (3) @(negedge m_clock);
    chk("reset_CEn", SRAM_CEn, 1);
    chk("reset_DEn", SRAM_DEn, 1);
    chk("reset_ADDR", SRAM_ADDR, 0);
    chk("reset_a_rdata", a_rdata, 0);
    #2 p_reset = 0;

    // Partial-lane read over cleared rdata, then an all-lanes-disabled read.
    do_req(0, 0, 2'b10, 18'h1A5A5, 16'h0, lat, cen, oen, wen, wpos, den, lb, ub);
    chk("be10_rdata", a_rdata, 16'hAB00);
    do_req(0, 0, 2'b00, 18'h1A5A5, 16'h0, lat, cen, oen, wen, wpos, den, lb, ub);
    chk("be00_rdata", a_rdata, 16'hAB00);
    chk("be00_lb_cycles", lb, 0);
    chk("be00_ub_cycles", ub, 0);
    chk("be00_ce_cycles", cen, N);

    // Full read from A.
    do_req(0, 0, 2'b11, 18'h00123, 16'h0, lat, cen, oen, wen, wpos, den, lb, ub);
    chk("rd_latency", lat, 4);
    chk("rd_ce_cycles", cen, 3);
    chk("rd_oe_cycles", oen, 3);
    chk("rd_rdata", a_rdata, 16'hBEEF);

    // Low-byte write from B at the top address.
    old_hi = {mem[18'h3FFFF][15:8], 8'h00};
    do_req(1, 1, 2'b01, 18'h3FFFF, 16'h1234, lat, cen, oen, wen, wpos, den, lb, ub);
    chk("wr_de_cycles", den, 3);
    chk("wr_we_cycles", wen, 1);
    chk("wr_we_position", wpos, 1);
    chk("wr_lb_cycles", lb, 3);
    chk("wr_ub_cycles", ub, 0);
    chk("wr_mem", mem[18'h3FFFF], old_hi | 16'h0034);

    // Both ports held: strict alternation starting with A (B was served last).
    @(negedge m_clock);
    set_port(0, 1, 0, 2'b11, 18'h0FFFF, 16'h0);
    set_port(1, 1, 0, 2'b11, 18'h2AAAA, 16'h0);
    for (int i = 0; i < 40 && ack_port.size() < 4; i++) begin
      @(negedge m_clock);
      if (a_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (b_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end
    a_req = 0; b_req = 0;
    chk("rr_ack_count", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size(); i++) chk("rr_order", ack_port[i], i % 2);
    for (int i = 1; i < ack_cyc.size(); i++) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 5);

    // Reset in the second cycle of a write aborts it; the held request then completes.
    @(negedge m_clock);
    @(negedge m_clock);
    set_port(0, 1, 1, 2'b11, 18'h00000, 16'h5A5A);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge m_clock);
      if (!SRAM_CEn) got = 1;
    end
    chk("abort_access_started", got, 1);
    @(negedge m_clock);
    #2 p_reset = 1;
    #1;
    chk("abort_CEn", SRAM_CEn, 1);
    chk("abort_WEn", SRAM_WEn, 1);
    chk("abort_DEn", SRAM_DEn, 1);
    @(negedge m_clock);
    chk("abort_no_ack", a_ack, 0);
    chk("abort_rdata", a_rdata, 0);
    #2 p_reset = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge m_clock);
      if (a_ack) got = 1;
    end
    chk("abort_retry_ack", got, 1);
    a_req = 0;

    // Randomized traffic on both ports, with one mid-run reset pulse.
    for (int i = 0; i < 1500; i++) begin
      @(negedge m_clock);
      if (i == 700) begin
        #2 p_reset = 1;
        @(negedge m_clock);
        #2 p_reset = 0;
      end
      for (int p = 0; p < 2; p++) begin
        logic rq, ak;
        rq = p ? b_req : a_req;
        ak = p ? b_ack : a_ack;
        if (rq) begin
          if (ak || $urandom_range(0, 39) == 0) set_port(p[0], 0, 0, 2'b00, 18'h0, 16'h0);
          else if ($urandom_range(0, 9) == 0)
            set_port(p[0], 1, 1'($urandom), 2'($urandom), pool[$urandom_range(0, 7)], 16'($urandom));
        end else if ($urandom_range(0, 2) == 0) begin
          set_port(p[0], 1, 1'($urandom), 2'($urandom), pool[$urandom_range(0, 7)], 16'($urandom));
        end
      end
    end
    a_req = 0; b_req = 0;
    repeat (N + 4) @(negedge m_clock);

    for (int i = 0; i < 8; i++) chk("final_mem", mem[pool[i]], ref_mem[pool[i]]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACC_CYC, default 3, SRAM access length in m_clock cycles; legal range 3..15.
REQ-002 m_clock  in  1  sole clock; all logic on rising edge.
REQ-003 p_reset  in  1  reset, asynchronous, active-high.
REQ-004 a_req / b_req  in  1  access request from port A (CPU) / port B (PPU/loader); held high until ack.
REQ-005 a_we / b_we  in  1  1=write, 0=read.
REQ-006 a_be / b_be  in  2  byte enables; bit0=low byte, bit1=high byte.
REQ-007 a_addr / b_addr  in  18  word address.
REQ-008 a_wdata / b_wdata  in  16  write data.
REQ-009 a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-010 a_rdata / b_rdata  out  16  registered read data per port.
REQ-011 SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_LBn, SRAM_UBn  out  1  active-low SRAM strobes, registered.
REQ-012 SRAM_DEn  out  1  data-bus drive enable; 0=drive SRAM_Dout onto pad, 1=release.
REQ-013 SRAM_ADDR  out  18  registered address.
REQ-014 SRAM_Din  in  16  pad read data;  SRAM_Dout  out  16  registered write data.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE; ACCESS lasts exactly ACC_CYC cycles (counter acc_cnt 0..ACC_CYC-1), DONE lasts exactly 1 cycle.
REQ-016 Requests SHALL be sampled only in IDLE; IDLE->ACCESS on any edge where a_req|b_req=1, else stay.
REQ-017 Arbitration SHALL be round-robin: single requester wins; on tie the port not granted last wins; last_grant resets to B so A wins the first tie.
REQ-018 On grant, addr, we, be, wdata of winning port SHALL be latched; later changes of requester inputs SHALL not affect the access.
REQ-019 In ACCESS: SRAM_CEn=0, SRAM_ADDR=latched addr, SRAM_LBn=~be[0], SRAM_UBn=~be[1].
REQ-020 Read in ACCESS: SRAM_OEn=0, SRAM_WEn=1, SRAM_DEn=1; SRAM_Din captured into granted port's rdata on last ACCESS cycle (acc_cnt=ACC_CYC-1); byte lanes with be=0 in rdata SHALL keep prior value.
REQ-021 Write in ACCESS: SRAM_OEn=1, SRAM_DEn=0 and SRAM_Dout=latched wdata all ACC_CYC cycles; SRAM_WEn=0 only for acc_cnt 1..ACC_CYC-2 (address/data setup and hold one cycle each).
REQ-022 In IDLE and DONE: all strobes 1, SRAM_DEn=1; SRAM_ADDR/SRAM_Dout hold last value.
REQ-023 DONE SHALL pulse ack of granted port for one cycle; rdata valid in that cycle and held until that port's next read; DONE->IDLE unconditionally.
REQ-024 Latency: req sampled at edge t -> ACCESS cycles t+1..t+ACC_CYC, ack high during cycle t+ACC_CYC+1; back-to-back throughput one access per ACC_CYC+2 cycles.
REQ-025 Requester dropping req during ACCESS SHALL not abort; access completes and ack still issues.
REQ-026 be=2'b00 SHALL run full access with LBn=UBn=1 and still ack; rdata unchanged.
REQ-027 a_ack and b_ack SHALL never be high in the same cycle; CEn=0 never coincides with both OEn=0 and DEn=0.

Reset
REQ-028 p_reset high SHALL immediately (asynchronously) force FSM=IDLE, acc_cnt=0, last_grant=B, all strobes=1, SRAM_DEn=1, SRAM_ADDR=0, SRAM_Dout=0, acks=0, rdata=0.
REQ-029 Reset mid-ACCESS SHALL abort the access with no ack; pending req after release is re-arbitrated from IDLE.

Verification
REQ-030 A read, addr=0x00123, be=11, model returns 0xBEEF, ACC_CYC=3 -> CEn/OEn low 3 cycles, a_ack one cycle at t+4, a_rdata=0xBEEF.
REQ-031 B write, addr=0x3FFFF, wdata=0x1234, be=01 -> DEn=0 3 cycles, WEn low only middle cycle, LBn=0, UBn=1, memory low byte=0x34, high unchanged.
REQ-032 a_req and b_req both held high continuously -> grants alternate A,B,A,B; acks 5 cycles apart; never simultaneous.
REQ-033 p_reset asserted at ACCESS cycle 2 of a write -> WEn/CEn go 1 and DEn goes 1 same instant, no ack; after release held a_req completes normally.
REQ-034 A read be=10 over prior a_rdata=0x0000 with SRAM_Din=0xABCD -> a_rdata=0xAB00; A read be=00 -> ack issued, a_rdata unchanged.
